// File: rtl/dvi_tx_timing_gen.sv
// DVI transmitter raster timing generator feeding the three TMDS encoders.
// Optional test-pattern source enabled by DVI_TX_TIMING_GEN_PATTERN_EN.
module dvi_tx_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
`ifdef DVI_TX_TIMING_GEN_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic [23:0] s_data,
  input  logic        s_user,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        out_frame_start,
  output logic        underflow,
  output logic        sync_err
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_VIS = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_VIS = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          vis;
  logic          at00;
  logic          wrap;
  logic          active;
  logic          hs_act;
  logic          vs_act;
  logic [23:0]   pix;
  logic          fs;
  logic          uf;
  logic          se;

  assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign at00   = (h_cnt == '0) && (v_cnt == '0);
  assign wrap   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign active = (state_q != IDLE);
  assign hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef DVI_TX_TIMING_GEN_PATTERN_EN
  logic        pat_q;
  logic [2:0]  bar;
  logic [23:0] bar_rgb;

  assign bar = 3'((32'(h_cnt) * 32'd8) / 32'(H_VISIBLE));
  assign bar_rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};

  // Pattern select only takes effect on a frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= 1'b0;
    end else if (!active || wrap) begin
      pat_q <= pattern_sel;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Raster counters: held at origin while idle
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Frame lock FSM, stream handshake and pixel select
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    pix     = '0;
    fs      = 1'b0;
    uf      = 1'b0;
    se      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ALIGN;
      end
      ALIGN: begin
`ifdef DVI_TX_TIMING_GEN_PATTERN_EN
        if (pat_q) begin
          if (vis) pix = bar_rgb;
          fs = at00;
        end else
`endif
        begin
          s_ready = s_valid && (!s_user || at00);
          if (at00 && s_valid && s_user) begin
            pix     = s_data;
            fs      = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
`ifdef DVI_TX_TIMING_GEN_PATTERN_EN
        if (pat_q) begin
          if (vis) pix = bar_rgb;
          fs      = at00;
          state_d = ALIGN;
        end else
`endif
        if (vis) begin
          s_ready = !(s_valid && (s_user != at00));
          if (!s_valid) begin
            uf      = 1'b1;
            state_d = ALIGN;
          end else if (s_user != at00) begin
            se      = 1'b1;
            state_d = ALIGN;
          end else begin
            pix = s_data;
            fs  = at00;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (active && wrap && !enable) state_d = IDLE;
  end

  // Registered encoder-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      out_de          <= 1'b0;
      out_hsync       <= ~HSYNC_POL;
      out_vsync       <= ~VSYNC_POL;
      out_r           <= '0;
      out_g           <= '0;
      out_b           <= '0;
      out_frame_start <= 1'b0;
      underflow       <= 1'b0;
      sync_err        <= 1'b0;
    end else begin
      out_de          <= active && vis;
      out_hsync       <= (active && hs_act) ? HSYNC_POL : ~HSYNC_POL;
      out_vsync       <= (active && vs_act) ? VSYNC_POL : ~VSYNC_POL;
      out_r           <= pix[23:16];
      out_g           <= pix[15:8];
      out_b           <= pix[7:0];
      out_frame_start <= fs;
      underflow       <= uf;
      sync_err        <= se;
    end
  end

endmodule

// File: tb/tb_dvi_tx_timing_gen.sv
// Scoreboard bench for dvi_tx_timing_gen on a 14x7 raster.
// Expected outputs queued by the driver, checked by a negedge monitor.
module tb_dvi_tx_timing_gen;

  localparam int HV = 8;
  localparam int VV = 4;
  localparam int HT = 14;
  localparam int VT = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] s_data;
  logic        s_user;
  logic        s_valid;
  logic        s_ready;
  logic        out_de;
  logic        out_hsync;
  logic        out_vsync;
  logic [7:0]  out_r;
  logic [7:0]  out_g;
  logic [7:0]  out_b;
  logic        out_frame_start;
  logic        underflow;
  logic        sync_err;

  dvi_tx_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
`ifdef DVI_TX_TIMING_GEN_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .s_data(s_data),
    .s_user(s_user),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .out_de(out_de),
    .out_hsync(out_hsync),
    .out_vsync(out_vsync),
    .out_r(out_r),
    .out_g(out_g),
    .out_b(out_b),
    .out_frame_start(out_frame_start),
    .underflow(underflow),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
    logic        fs;
    logic        uf;
    logic        se;
  } exp_t;

  exp_t sbq[$];
  exp_t pend;
  exp_t got;
  exp_t mon_e;
  bit   have_pend;
  bit   run;
  int   bh;
  int   bv;
  int   n_chk;
  int   n_fail;

  assign got = {out_de, out_hsync, out_vsync, out_r, out_g, out_b,
                out_frame_start, underflow, sync_err};

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      n_chk++;
      if (got !== mon_e) begin
        n_fail++;
        $display("FAIL out@%0t: got de%b hs%b vs%b pix%h fs%b uf%b se%b want de%b hs%b vs%b pix%h fs%b uf%b se%b",
                 $time, got.de, got.hs, got.vs, got.pix, got.fs, got.uf, got.se,
                 mon_e.de, mon_e.hs, mon_e.vs, mon_e.pix, mon_e.fs, mon_e.uf, mon_e.se);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, g, e);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_de"}, 32'(out_de), 32'd0);
    chk({nm, "_hs"}, 32'(out_hsync), 32'd1);
    chk({nm, "_vs"}, 32'(out_vsync), 32'd1);
    chk({nm, "_rgb"}, {8'd0, out_r, out_g, out_b}, 32'd0);
    chk({nm, "_pulses"}, 32'({out_frame_start, underflow, sync_err}), 32'd0);
    chk({nm, "_ready"}, 32'(s_ready), 32'd0);
  endtask

  task automatic cyc(input logic en, input logic sv, input logic su,
                     input logic [23:0] sd, input logic erdy,
                     input logic [23:0] epix, input logic efs,
                     input logic euf, input logic ese);
    @(posedge clk);
    #1;
    if (have_pend) sbq.push_back(pend);
    enable  = en;
    s_valid = sv;
    s_user  = su;
    s_data  = sd;
    #1;
    chk("s_ready", 32'(s_ready), 32'(erdy));
    if (run) begin
      pend.de  = (bh < HV) && (bv < VV);
      pend.hs  = !(bh >= 10 && bh < 12);
      pend.vs  = !(bv == 5);
      pend.pix = epix;
      pend.fs  = efs;
      pend.uf  = euf;
      pend.se  = ese;
    end else begin
      pend = '{de: 1'b0, hs: 1'b1, vs: 1'b1, pix: 24'd0,
               fs: 1'b0, uf: 1'b0, se: 1'b0};
    end
    have_pend = 1'b1;
    if (run) begin
      if (bh == HT - 1 && bv == VT - 1 && !en) run = 1'b0;
      if (bh == HT - 1) begin
        bh = 0;
        bv = (bv == VT - 1) ? 0 : bv + 1;
      end else begin
        bh = bh + 1;
      end
    end else if (en) begin
      run = 1'b1;
    end
  endtask

  task automatic frame(input int base, input int drop_idx, input int err_idx,
                       input int err_data, input int en_lo, input int en_hi);
    int k;
    int idx;
    bit locked;
    bit hold;
    logic en, sv, su, rdy, fs, uf, se;
    logic [23:0] sd, epix;
    k = 0;
    locked = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < HT * VT; i++) begin
      en = !(i >= en_lo && i < en_hi);
      sv = 0; su = 0; sd = '0; epix = '0;
      rdy = 0; fs = 0; uf = 0; se = 0;
      if (bh < HV && bv < VV) begin
        idx = bv * HV + bh;
        if (locked && idx == drop_idx) begin
          rdy = 1; uf = 1; locked = 0;
        end else if (locked && idx == err_idx) begin
          sv = 1; su = 1; sd = 24'(err_data);
          se = 1; locked = 0; hold = 1;
        end else if (locked) begin
          sv = 1; su = (k == 0); sd = 24'(base + k);
          rdy = 1; epix = sd; fs = (idx == 0); k++;
        end else if (hold) begin
          sv = 1; su = 1; sd = 24'(err_data);
        end else if (k < HV * VV) begin
          sv = 1; sd = 24'(base + k); rdy = 1; k++;
        end
      end else begin
        if (hold) begin
          sv = 1; su = 1; sd = 24'(err_data);
        end else if (k < HV * VV) begin
          sv = 1; sd = 24'(base + k);
          if (!locked) begin
            rdy = 1; k++;
          end
        end
      end
      cyc(en, sv, su, sd, rdy, epix, fs, uf, se);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; have_pend = 0; run = 0; bh = 0; bv = 0;
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_user = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;

    // Free-running blank frame; stale beats dropped just before the wrap
    cyc(1, 0, 0, 24'd0, 0, 24'd0, 0, 0, 0);
    for (int i = 0; i < HT * VT; i++) begin
      if (i >= HT * VT - 4)
        cyc(1, 1, 0, 24'(32'hEE0000 + i), 1, 24'd0, 0, 0, 0);
      else
        cyc(1, 0, 0, 24'd0, 0, 24'd0, 0, 0, 0);
    end
    chk("pos_after_blank", 32'(bh + bv), 32'd0);

    // Lock, pixels 1..32
    frame(32'h01, -1, -1, 0, -1, -1);
    // Underflow at pixel (2,1), rest of frame black
    frame(32'h21, 10, -1, 0, -1, -1);
    // Relock; enable glitch mid-frame must not stop
    frame(32'h41, -1, -1, 0, 30, 40);
    // Misplaced frame-start beat at pixel 20, held until next frame
    frame(32'h61, -1, 20, 32'h81, -1, -1);
    // Relock on held beat; enable dropped mid-frame -> idle after wrap
    frame(32'h81, -1, -1, 0, 20, HT * VT);
    chk("idle_after_stop", 32'(run), 32'd0);

    repeat (4) cyc(0, 1, 0, 24'h123456, 0, 24'd0, 0, 0, 0);
    cyc(1, 0, 0, 24'd0, 0, 24'd0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 24'd0, 0, 24'd0, 0, 0, 0);

    // Reset in the middle of a line
    @(posedge clk);
    #1;
    sbq.push_back(pend);
    have_pend = 0;
    reset = 1'b1;
    s_valid = 1'b1;
    s_user = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    reset = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("post_rst_idle");

    for (int i = 0; i < 4 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
